// File: rtl/rng_health_monitor.sv
// rtl/rng_health_monitor.sv - RNG byte health tests (repetition + proportion) gating a small output FIFO
module rng_health_monitor #(
    parameter int RCT_CUTOFF    = 4,
    parameter int APT_WINDOW    = 512,
    parameter int APT_CUTOFF    = 13,
    parameter int STARTUP_BYTES = 1024,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        clear_fail,
    output logic        rct_fail,
    output logic        apt_fail,
    output logic [15:0] drop_count
);

    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int WW = $clog2(APT_WINDOW);
    localparam int CW = $clog2(APT_CUTOFF + 1);
    localparam int SW = $clog2(STARTUP_BYTES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_t;

    state_t        state_q, state_d;
    logic [7:0]    last_byte_q, last_byte_d;
    logic [RW-1:0] run_len_q, run_len_d;
    logic [WW-1:0] win_pos_q, win_pos_d;
    logic [7:0]    ref_byte_q, ref_byte_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [SW-1:0] su_cnt_q, su_cnt_d;
    logic          rct_fail_q, rct_fail_d;
    logic          apt_fail_q, apt_fail_d;
    logic [15:0]   drop_q, drop_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          accept;
    logic [RW-1:0] rct_run;
    logic [CW-1:0] apt_cnt;
    logic          rct_trip, apt_trip, fail_now;
    logic          push, pop, full, empty, wr_en;
    logic [SW-1:0] su_next;

    // run_len_q == 0 marks "no byte seen since reset/clear"
    always_comb begin
        accept   = in_valid && (state_q != ST_FAIL);
        rct_run  = (run_len_q == '0 || in_byte != last_byte_q) ? RW'(1) : run_len_q + 1'b1;
        if (win_pos_q == '0)
            apt_cnt = CW'(1);
        else if (in_byte == ref_byte_q)
            apt_cnt = ref_cnt_q + 1'b1;
        else
            apt_cnt = ref_cnt_q;
        rct_trip = accept && (rct_run >= RW'(RCT_CUTOFF));
        apt_trip = accept && (apt_cnt >= CW'(APT_CUTOFF));
        fail_now = rct_trip || apt_trip;
        su_next  = su_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        last_byte_d = last_byte_q;
        run_len_d   = run_len_q;
        win_pos_d   = win_pos_q;
        ref_byte_d  = ref_byte_q;
        ref_cnt_d   = ref_cnt_q;
        su_cnt_d    = su_cnt_q;
        rct_fail_d  = rct_fail_q;
        apt_fail_d  = apt_fail_q;
        if (state_q == ST_FAIL) begin
            if (clear_fail) begin
                state_d     = ST_STARTUP;
                last_byte_d = '0;
                run_len_d   = '0;
                win_pos_d   = '0;
                ref_byte_d  = '0;
                ref_cnt_d   = '0;
                su_cnt_d    = '0;
                rct_fail_d  = 1'b0;
                apt_fail_d  = 1'b0;
            end
        end else if (in_valid) begin
            last_byte_d = in_byte;
            run_len_d   = rct_run;
            win_pos_d   = win_pos_q + 1'b1;
            ref_cnt_d   = apt_cnt;
            if (win_pos_q == '0)
                ref_byte_d = in_byte;
            if (fail_now) begin
                rct_fail_d = rct_fail_q || rct_trip;
                apt_fail_d = apt_fail_q || apt_trip;
                state_d    = ST_FAIL;
            end else if (state_q == ST_STARTUP) begin
                su_cnt_d = su_next;
                if (su_next == SW'(STARTUP_BYTES))
                    state_d = ST_RUN;
            end
        end
    end

    // FIFO is held flushed for as long as the block sits in FAIL
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        out_valid = !empty && (state_q != ST_FAIL);
        out_byte  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
        pop       = out_valid && out_ready;
        push      = accept && (state_q == ST_RUN) && !fail_now;
        wr_en     = push && (!full || pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        drop_d    = drop_q;
        if (state_q == ST_FAIL) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !wr_en && drop_q != 16'hFFFF)
                drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_STARTUP;
            last_byte_q <= '0;
            run_len_q   <= '0;
            win_pos_q   <= '0;
            ref_byte_q  <= '0;
            ref_cnt_q   <= '0;
            su_cnt_q    <= '0;
            rct_fail_q  <= 1'b0;
            apt_fail_q  <= 1'b0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_byte_q <= last_byte_d;
            run_len_q   <= run_len_d;
            win_pos_q   <= win_pos_d;
            ref_byte_q  <= ref_byte_d;
            ref_cnt_q   <= ref_cnt_d;
            su_cnt_q    <= su_cnt_d;
            rct_fail_q  <= rct_fail_d;
            apt_fail_q  <= apt_fail_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= in_byte;
    end

    assign rct_fail   = rct_fail_q;
    assign apt_fail   = apt_fail_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// tb/tb_rng_health_monitor.sv - directed bench for rng_health_monitor
module tb_rng_health_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        clear_fail = 1'b0;
    logic        rct_fail, apt_fail;
    logic [15:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    rng_health_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear_fail (clear_fail),
        .rct_fail   (rct_fail),
        .apt_fail   (apt_fail),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_pulse(input logic with_byte);
        @(negedge clk);
        clear_fail = 1'b1;
        in_valid   = with_byte;
        in_byte    = 8'hC3;
        @(posedge clk);
        #1;
        clear_fail = 1'b0;
        in_valid   = 1'b0;
    endtask

    // 1024 quiet start-up bytes, then 0x5A must show up one cycle after its strobe
    task automatic do_startup(input string tag);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            send(8'(i));
            if (out_valid) saw = 1'b1;
        end
        chk({tag, "_quiet"}, saw, 0);
        send(8'h5A);
        chk({tag, "_first_valid"}, out_valid, 1);
        chk({tag, "_first_byte"}, out_byte, 8'h5A);
    endtask

    task automatic pad_to_window();
        for (int j = 0; j < 511; j++) send(8'(j));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_rct", rct_fail, 0);
        chk("rst_apt", apt_fail, 0);
        chk("rst_drop", drop_count, 0);
        #12;
        @(negedge clk);
        reset = 1'b1;

        do_startup("su1");

        // FIFO overflow: 20 bytes into 16 slots with no consumer
        @(posedge clk);
        #1;
        chk("drain_5a", out_valid, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(8'h30 + 8'(i));
        chk("ovf_drop", drop_count, 4);
        chk("ovf_head", out_byte, 8'h30);
        out_ready = 1'b1;
        send(8'h44);
        chk("full_pushpop_drop", drop_count, 4);
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_byte", out_byte, (i < 15) ? 8'h31 + 8'(i) : 8'h44);
            @(posedge clk);
            #1;
        end
        chk("drain_empty", out_valid, 0);

        clear_pulse(1'b0);
        send(8'h77);
        chk("clr_in_run_valid", out_valid, 1);
        chk("clr_in_run_byte", out_byte, 8'h77);

        // repetition test
        send(8'h11);
        chk("rct_b0", out_byte, 8'h11);
        for (int i = 0; i < 3; i++) begin
            send(8'h22);
            chk("rct_b_valid", out_valid, 1);
            chk("rct_b_byte", out_byte, 8'h22);
            chk("rct_not_yet", rct_fail, 0);
        end
        send(8'h22);
        chk("rct_trip", rct_fail, 1);
        chk("rct_apt_clear", apt_fail, 0);
        chk("rct_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("rct_out_valid_later", out_valid, 0);
        send(8'h99);
        chk("fail_ignores_input", out_valid, 0);
        chk("fail_drop_kept", drop_count, 4);

        clear_pulse(1'b1);
        chk("clr_rct", rct_fail, 0);
        chk("clr_apt", apt_fail, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_drop_kept", drop_count, 4);
        do_startup("su2");

        // proportion test: 13 occurrences of the window head
        pad_to_window();
        for (int k = 0; k < 13; k++) begin
            if (k == 12) chk("apt_not_yet", apt_fail, 0);
            send(8'hA5);
            if (k < 12) send(8'(k + 1));
        end
        chk("apt_trip", apt_fail, 1);
        chk("apt_rct_clear", rct_fail, 0);
        chk("apt_out_valid", out_valid, 0);

        // 12 occurrences do not trip, and counting restarts at the wrap
        clear_pulse(1'b0);
        do_startup("su3");
        pad_to_window();
        for (int k = 0; k < 12; k++) begin
            send(8'hA5);
            send(8'(k + 1));
        end
        for (int k = 0; k < 488; k++) send(8'(k % 128));
        chk("apt12_no_fail", apt_fail, 0);
        for (int k = 0; k < 12; k++) begin
            send(8'hA5);
            send(8'(k + 1));
        end
        chk("apt_wrap_no_fail", apt_fail, 0);
        chk("apt_wrap_valid", out_valid, 1);
        send(8'hA5);
        chk("apt_wrap_trip", apt_fail, 1);

        // asynchronous reset in the middle of RUN
        clear_pulse(1'b0);
        do_startup("su4");
        out_ready = 1'b0;
        send(8'h61);
        send(8'h62);
        send(8'h63);
        chk("mid_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_byte", out_byte, 8'h00);
        chk("arst_drop", drop_count, 0);
        chk("arst_rct", rct_fail, 0);
        chk("arst_apt", apt_fail, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        do_startup("su5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
